multitap_linebuffer: RTL
========================

Name: multitap_linebuffer

Overview:
- Streaming delay line that outputs, per accepted sample, the current sample plus TAPS_P copies delayed by k*L accepted samples (k=1..TAPS_P).
- Generalises the fixed two-port RAM delay: tap count is a parameter, line length L is programmable at runtime, fill-status masking is built in, and a synchronous clear is provided.
- Sits in front of the Sobel window generator; with TAPS_P=2 it supplies the three image rows of a 3x3 kernel.
- Delay counts accepted samples (valid_i & ready_o), not clock cycles.

Parameters:
WIDTH_P, 8, bits per sample
MAX_DELAY_P, 640, maximum line length L; per-tap storage depth
TAPS_P, 2, number of delayed taps (>=1; $fatal at elaboration if 0)

Ports:
clk_i  input  1  clock
rst_i  input  1  asynchronous reset, active-high
clear_i  input  1  synchronous flush; also latches line_len_i
line_len_i  input  $clog2(MAX_DELAY_P+1)  line length L; sampled only on reset release and on clear_i
valid_i  input  1  input sample valid
ready_o  output  1  block can accept
data_i  input  WIDTH_P  input sample
valid_o  output  1  output word valid
ready_i  input  1  downstream accepts
data_o  output  (TAPS_P+1)*WIDTH_P  slice k (bits k*WIDTH_P +: WIDTH_P) = tap k; tap 0 = current sample
primed_o  output  1  all taps hold real (non-masked) data

Behaviour:
- Reset (async, rst_i=1):
  - valid_o=0, data_o=0, primed_o=0.
  - Pointers and fill count cleared to 0.
  - L register loads the clamped line_len_i on the first clk edge after rst_i deasserts.
- Clamping: line_len_i=0 is treated as 1; line_len_i > MAX_DELAY_P is treated as MAX_DELAY_P.
- Handshake:
  - ready_o = ~valid_o | ready_i.
  - Accept = valid_i & ready_o.
  - Output word registered: latency 1 cycle from accept to valid_o.
  - valid_o and data_o hold stable while valid_o & ~ready_i.
  - Cycle with no accept and ready_i=1 drops valid_o to 0.
- Data rule, for accept index n (0-based since last reset/clear):
  - tap0 = sample n.
  - tap k = sample n-k*L if n >= k*L, else 0. Uninitialised RAM must never reach data_o.
- Storage:
  - One circular buffer of depth MAX_DELAY_P per tap.
  - Pointer advances only on accept and wraps from L-1 to 0.
  - Tap k+1 buffer is fed by tap k's delayed output.
  - Synchronous-read RAM allowed; the implementation must still meet the 1-cycle latency with no bubbles at full throughput (1 accept/cycle sustained).
- Fill count:
  - Saturates at TAPS_P*L.
  - primed_o=1 in the same cycle valid_o first presents accept index TAPS_P*L, and stays 1 until reset/clear.
- clear_i (synchronous):
  - Has priority over accept; ready_o forced 0 during the clear cycle, and any input that cycle is not accepted.
  - Next cycle: valid_o=0, data_o=0, primed_o=0, pointers and fill count = 0, L = clamped line_len_i.
- line_len_i changes without clear_i are ignored.
- Reset or clear mid-stream discards all in-flight and stored data; masking guarantees zeros on every tap until refilled.
- Pointer wrap with simultaneous stall: pointer and RAM are untouched on stalled cycles; no writes occur without accept.

Test Plan:
- WIDTH_P=8, MAX_DELAY_P=16, TAPS_P=2, L=4, ready_i=1, feed 0..11 back-to-back -> valid_o every cycle after the first; accept n=3 outputs {t2,t1,t0}={0,0,3}; n=5 -> {0,1,5}; n=8 -> {0,4,8} with primed_o rising with it; n=11 -> {3,7,11}.
- Same config, ready_i toggled 1,0,0,1 during samples 6..9 -> ready_o=0 while valid_o&~ready_i; data_o held; sequence resumes with no loss or duplication ({1,5,9} for n=9).
- Stream 10 samples at L=4, then clear_i with line_len_i=3 and feed 0..8 -> zeros until masking lifts; n=6 -> {0,3,6}; primed_o at n=6; ready_o=0 during clear cycle.
- line_len_i=0 then 20 (with clear) -> behaves as L=1 (n=2 -> {0,1,2}) and L=16 respectively.
- Assert rst_i asynchronously mid-stream at L=4 -> valid_o/data_o/primed_o = 0 immediately; restarting 0..4 gives n=4 -> {0,0,4} (no stale data).
- Random valid_i/ready_i, 1000 samples, L=7, TAPS_P=3 against a scoreboard model -> every output word matches the tap rule exactly.

Source files
------------

// File: rtl/multitap_linebuffer.sv
// Multi-tap streaming line buffer: emits the current sample plus TAPS_P copies
// delayed by k*L accepted samples, masked to zero until each tap has filled.
module multitap_linebuffer #(
    parameter int WIDTH_P     = 8,
    parameter int MAX_DELAY_P = 640,
    parameter int TAPS_P      = 2
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                clear_i,
    input  logic [$clog2(MAX_DELAY_P+1)-1:0]    line_len_i,
    input  logic                                valid_i,
    output logic                                ready_o,
    input  logic [WIDTH_P-1:0]                  data_i,
    output logic                                valid_o,
    input  logic                                ready_i,
    output logic [(TAPS_P+1)*WIDTH_P-1:0]       data_o,
    output logic                                primed_o
);
    localparam int LW    = $clog2(MAX_DELAY_P + 1);
    localparam int PW    = (MAX_DELAY_P > 1) ? $clog2(MAX_DELAY_P) : 1;
    localparam int TAPSC = (TAPS_P > 0) ? TAPS_P : 1;
    localparam int FW    = $clog2(TAPSC * MAX_DELAY_P + 1);
    localparam int OW    = (TAPSC + 1) * WIDTH_P;

    if (TAPS_P < 1) begin : g_bad_taps
        $fatal(1, "multitap_linebuffer: TAPS_P must be at least 1");
    end

    function automatic logic [LW-1:0] clamp_len(input logic [LW-1:0] len);
        logic [LW-1:0] res;
        if (len == {LW{1'b0}}) begin
            res = LW'(1);
        end else if (len > LW'(MAX_DELAY_P)) begin
            res = LW'(MAX_DELAY_P);
        end else begin
            res = len;
        end
        return res;
    endfunction

    logic [LW-1:0]          len_r;
    logic                   pending_r;
    logic [PW-1:0]          ptr_r;
    logic [FW-1:0]          fill_r;
    logic                   valid_r;
    logic [OW-1:0]          data_r;
    logic                   primed_r;

    logic [LW-1:0]          len_eff_s;
    logic [PW-1:0]          ptr_nxt_s;
    logic [FW-1:0]          full_s;
    logic                   ready_s;
    logic                   accept_s;
    logic [TAPSC-1:0]       en_s;
    logic [TAPSC*WIDTH_P-1:0] rd_s;
    logic [OW-1:0]          word_s;

    // The length register is still loading on the first edge after reset, so use the port then
    always_comb begin
        if (pending_r) begin
            len_eff_s = clamp_len(line_len_i);
        end else begin
            len_eff_s = len_r;
        end
    end

    assign full_s    = FW'(TAPSC) * FW'(len_eff_s);
    assign ptr_nxt_s = (LW'(ptr_r) == (len_eff_s - LW'(1))) ? {PW{1'b0}} : (ptr_r + PW'(1));
    assign ready_s   = ~clear_i & (~valid_r | ready_i);
    assign accept_s  = valid_i & ready_s;

    assign word_s[WIDTH_P-1:0] = data_i;

    genvar g;
    for (g = 0; g < TAPSC; g++) begin : g_tap
        logic [WIDTH_P-1:0] mem_r [MAX_DELAY_P];

        // Tap g+1 is live once g+1 full lines have been accepted; before that it reads as zero
        assign en_s[g] = (fill_r >= (FW'(g + 1) * FW'(len_eff_s)));
        assign rd_s[g*WIDTH_P +: WIDTH_P] = mem_r[ptr_r];
        assign word_s[(g+1)*WIDTH_P +: WIDTH_P] =
            en_s[g] ? rd_s[g*WIDTH_P +: WIDTH_P] : {WIDTH_P{1'b0}};

        // Circular buffer fed by the masked previous tap, written only on accepted samples
        always_ff @(posedge clk_i) begin
            if (accept_s) begin
                mem_r[ptr_r] <= word_s[g*WIDTH_P +: WIDTH_P];
            end
        end
    end

    // Output register, shared pointer, fill count and line-length capture
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_r   <= 1'b0;
            data_r    <= {OW{1'b0}};
            primed_r  <= 1'b0;
            ptr_r     <= {PW{1'b0}};
            fill_r    <= {FW{1'b0}};
            len_r     <= LW'(1);
            pending_r <= 1'b1;
        end else if (clear_i) begin
            valid_r   <= 1'b0;
            data_r    <= {OW{1'b0}};
            primed_r  <= 1'b0;
            ptr_r     <= {PW{1'b0}};
            fill_r    <= {FW{1'b0}};
            len_r     <= clamp_len(line_len_i);
            pending_r <= 1'b0;
        end else begin
            pending_r <= 1'b0;
            len_r     <= len_eff_s;
            if (accept_s) begin
                valid_r <= 1'b1;
                data_r  <= word_s;
                ptr_r   <= ptr_nxt_s;
                if (fill_r < full_s) begin
                    fill_r <= fill_r + FW'(1);
                end else begin
                    fill_r <= fill_r;
                end
                if (fill_r >= full_s) begin
                    primed_r <= 1'b1;
                end else begin
                    primed_r <= primed_r;
                end
            end else if (ready_i) begin
                valid_r <= 1'b0;
            end else begin
                valid_r <= valid_r;
            end
        end
    end

    assign ready_o  = ready_s;
    assign valid_o  = valid_r;
    assign data_o   = data_r[(TAPS_P+1)*WIDTH_P-1:0];
    assign primed_o = primed_r;

endmodule
